// File: rtl/proc_control_fsm_if.sv
// Control bundle between proc_control_fsm (master) and its instruction ROM / datapath (slave).
interface proc_control_fsm_if;
   logic        run;
   logic [22:0] code;
   logic [4:0]  pc;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [2:0]  rf_raddr;
   logic [1:0]  bus_sel;
   logic [15:0] imm;
   logic        a_load;
   logic        alu_add;
   logic        busy;
   logic        done;
   logic        halted;
   logic        illegal;

   modport master (
      input  run, code,
      output pc, rf_we, rf_waddr, rf_raddr, bus_sel, imm,
             a_load, alu_add, busy, done, halted, illegal
   );

   modport slave (
      output run, code,
      input  pc, rf_we, rf_waddr, rf_raddr, bus_sel, imm,
             a_load, alu_add, busy, done, halted, illegal
   );
endinterface

// File: rtl/proc_control_fsm.sv
// Multi-cycle control FSM for a tiny LOAD/MOV/ADD processor with a 32-word instruction ROM.
// Optional: define ILLEGAL_OP_TRAP_EN to halt (with illegal=1) on undefined opcodes instead of skipping them.
module proc_control_fsm (
   input  logic               clk,
   input  logic               rst,
   proc_control_fsm_if.master ctl
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EX1, EX2, EX3, HALT} state_e;

   localparam logic [3:0] OP_HALT = 4'h0;
   localparam logic [3:0] OP_LOAD = 4'h1;
   localparam logic [3:0] OP_MOV  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;

   state_e      state_q, state_d;
   logic [4:0]  pc_q, pc_d;
   logic [22:0] ir_q, ir_d;
   logic        done_q, done_d;
   logic [3:0]  op;
   logic [2:0]  rx, ry;

   assign op = ir_q[22:19];
   assign rx = ir_q[18:16];
   assign ry = ir_q[15:13];

`ifdef ILLEGAL_OP_TRAP_EN
   logic illegal_q, illegal_d;
   assign ctl.illegal = illegal_q;
`else
   assign ctl.illegal = 1'b0;
`endif

   assign ctl.pc     = pc_q;
   assign ctl.done   = done_q;
   assign ctl.halted = (state_q == HALT);
   assign ctl.busy   = (state_q != IDLE) && (state_q != HALT);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         done_q    <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         done_q    <= done_d;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_d    = illegal_q;
`endif
      ctl.rf_we    = 1'b0;
      ctl.rf_waddr = '0;
      ctl.rf_raddr = '0;
      ctl.bus_sel  = 2'b00;
      ctl.imm      = '0;
      ctl.a_load   = 1'b0;
      ctl.alu_add  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ctl.run) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            ir_d    = ctl.code;
            state_d = DECODE;
         end
         DECODE: begin
            case (op)
               OP_HALT:                 state_d = HALT;
               OP_LOAD, OP_MOV, OP_ADD: state_d = EX1;
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  illegal_d = 1'b1;
                  state_d   = HALT;
`else
                  pc_d      = pc_q + 5'd1;
                  state_d   = FETCH;
`endif
               end
            endcase
         end
         EX1: begin
            case (op)
               OP_LOAD: begin
                  ctl.rf_we    = 1'b1;
                  ctl.rf_waddr = rx;
                  ctl.bus_sel  = 2'b01;
                  ctl.imm      = ir_q[15:0];
                  pc_d         = pc_q + 5'd1;
                  state_d      = FETCH;
               end
               OP_MOV: begin
                  ctl.rf_raddr = ry;
                  ctl.bus_sel  = 2'b10;
                  ctl.rf_we    = 1'b1;
                  ctl.rf_waddr = rx;
                  pc_d         = pc_q + 5'd1;
                  state_d      = FETCH;
               end
               OP_ADD: begin
                  ctl.rf_raddr = rx;
                  ctl.bus_sel  = 2'b10;
                  ctl.a_load   = 1'b1;
                  state_d      = EX2;
               end
               default: state_d = IDLE;
            endcase
         end
         EX2: begin
            ctl.rf_raddr = ry;
            ctl.bus_sel  = 2'b10;
            ctl.alu_add  = 1'b1;
            state_d      = EX3;
         end
         EX3: begin
            ctl.bus_sel  = 2'b11;
            ctl.rf_we    = 1'b1;
            ctl.rf_waddr = rx;
            pc_d         = pc_q + 5'd1;
            state_d      = FETCH;
         end
         HALT: begin
            if (ctl.run) begin
               pc_d      = '0;
`ifdef ILLEGAL_OP_TRAP_EN
               illegal_d = 1'b0;
`endif
               state_d   = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase

      // done is registered so it is high exactly for the first cycle spent in HALT
      done_d = (state_d == HALT) && (state_q != HALT);
   end
endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed, table-driven bench for proc_control_fsm; expected outputs are hand-computed per cycle.
module tb_proc_control_fsm;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   proc_control_fsm_if ifc ();
   proc_control_fsm dut (.clk(clk), .rst(rst), .ctl(ifc.master));

   typedef struct packed {
      logic [4:0]  pc;
      logic        rf_we;
      logic [2:0]  rf_waddr;
      logic [2:0]  rf_raddr;
      logic [1:0]  bus_sel;
      logic [15:0] imm;
      logic        a_load;
      logic        alu_add;
      logic        busy;
      logic        done;
      logic        halted;
      logic        illegal;
   } out_t;

   typedef struct {
      string       name;
      logic        rst;
      logic        run;
      logic [22:0] code;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [22:0] mk(input logic [3:0] op, input logic [2:0] rx, input logic [15:0] imm16);
      return {op, rx, imm16};
   endfunction

   function automatic out_t ex(input logic [4:0] pc, input logic we, input logic [2:0] wa,
                               input logic [2:0] ra, input logic [1:0] bs, input logic [15:0] im,
                               input logic al, input logic aa, input logic bz, input logic dn,
                               input logic hl, input logic il);
      return {pc, we, wa, ra, bs, im, al, aa, bz, dn, hl, il};
   endfunction

   function automatic out_t busy_at(input logic [4:0] pc);
      return ex(pc, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic out_t sample();
      out_t s;
      s.pc       = ifc.pc;
      s.rf_we    = ifc.rf_we;
      s.rf_waddr = ifc.rf_waddr;
      s.rf_raddr = ifc.rf_raddr;
      s.bus_sel  = ifc.bus_sel;
      s.imm      = ifc.imm;
      s.a_load   = ifc.a_load;
      s.alu_add  = ifc.alu_add;
      s.busy     = ifc.busy;
      s.done     = ifc.done;
      s.halted   = ifc.halted;
      s.illegal  = ifc.illegal;
      return s;
   endfunction

   task automatic check(input string name, input out_t act, input out_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got pc=%0d we=%b wa=%0d ra=%0d bs=%b imm=%h al=%b aa=%b busy=%b done=%b halt=%b ill=%b, want pc=%0d we=%b wa=%0d ra=%0d bs=%b imm=%h al=%b aa=%b busy=%b done=%b halt=%b ill=%b",
                  name, act.pc, act.rf_we, act.rf_waddr, act.rf_raddr, act.bus_sel, act.imm, act.a_load,
                  act.alu_add, act.busy, act.done, act.halted, act.illegal,
                  exp.pc, exp.rf_we, exp.rf_waddr, exp.rf_raddr, exp.bus_sel, exp.imm, exp.a_load,
                  exp.alu_add, exp.busy, exp.done, exp.halted, exp.illegal);
      end
   endtask

   // inputs are applied before the edge; outputs are sampled 1 time unit after it
   task automatic step(input logic r, input logic rn, input logic [22:0] c);
      rst      = r;
      ifc.run  = rn;
      ifc.code = c;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input string name, input logic r, input logic rn,
                               input logic [22:0] c, input out_t e);
      vec_t v;
      v.name = name; v.rst = r; v.run = rn; v.code = c; v.exp = e;
      vecs.push_back(v);
   endfunction

   logic [22:0] c_load, c_mov, c_add, c_ld2, c_bad, c_halt, c_fill;
   out_t        zero;

   initial begin
      rst      = 1'b1;
      ifc.run  = 1'b0;
      ifc.code = '0;
      zero     = '0;

      c_load = mk(4'h1, 3'd0, 16'h000C);
      c_mov  = mk(4'h2, 3'd5, {3'd7, 13'h0555});
      c_add  = mk(4'h3, 3'd3, {3'd0, 13'h1ABC});
      c_ld2  = mk(4'h1, 3'd2, 16'h0001);
      c_bad  = mk(4'h5, 3'd6, 16'hFFFF);
      c_halt = mk(4'h0, 3'd0, 16'h0000);
      c_fill = mk(4'h1, 3'd1, 16'h1234);

      add("reset",          1'b1, 1'b0, '0,     zero);
      add("rst_over_run",   1'b1, 1'b1, c_load, zero);
      add("idle_hold",      1'b0, 1'b0, c_load, zero);
      add("run_to_fetch",   1'b0, 1'b1, c_load, busy_at(5'd0));
      add("load_decode",    1'b0, 1'b0, c_load, busy_at(5'd0));
      add("load_ex1",       1'b0, 1'b0, c_mov,
          ex(5'd0, 1'b1, 3'd0, 3'd0, 2'b01, 16'h000C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      add("mov_fetch",      1'b0, 1'b0, c_mov,  busy_at(5'd1));
      add("mov_decode",     1'b0, 1'b1, c_mov,  busy_at(5'd1));
      add("mov_ex1",        1'b0, 1'b1, c_add,
          ex(5'd1, 1'b1, 3'd5, 3'd7, 2'b10, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      add("add_fetch",      1'b0, 1'b0, c_add,  busy_at(5'd2));
      add("add_decode",     1'b0, 1'b1, c_add,  busy_at(5'd2));
      add("add_ex1",        1'b0, 1'b0, c_ld2,
          ex(5'd2, 1'b0, 3'd0, 3'd3, 2'b10, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      add("add_ex2",        1'b0, 1'b1, c_ld2,
          ex(5'd2, 1'b0, 3'd0, 3'd0, 2'b10, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      add("add_ex3",        1'b0, 1'b0, c_ld2,
          ex(5'd2, 1'b1, 3'd3, 3'd0, 2'b11, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      add("ld2_fetch",      1'b0, 1'b0, c_ld2,  busy_at(5'd3));
      add("ld2_decode",     1'b0, 1'b0, c_ld2,  busy_at(5'd3));
      add("ld2_ex1",        1'b0, 1'b0, c_bad,
          ex(5'd3, 1'b1, 3'd2, 3'd0, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      add("bad_fetch",      1'b0, 1'b0, c_bad,  busy_at(5'd4));
      add("bad_decode",     1'b0, 1'b0, c_bad,  busy_at(5'd4));
`ifdef ILLEGAL_OP_TRAP_EN
      add("bad_trap",       1'b0, 1'b0, c_bad,
          ex(5'd4, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      add("trap_hold",      1'b0, 1'b0, c_bad,
          ex(5'd4, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      add("trap_restart",   1'b0, 1'b1, c_bad,  busy_at(5'd0));
`else
      add("bad_skip",       1'b0, 1'b0, c_bad,  busy_at(5'd5));
      add("bad_skip_dec",   1'b0, 1'b0, c_bad,  busy_at(5'd5));
`endif
      add("reset_again",    1'b1, 1'b0, '0,     zero);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].run, vecs[i].code);
         check(vecs[i].name, sample(), vecs[i].exp);
      end

      // HALT at pc=12: done pulse, pc held, then restart from 0
      step(1'b0, 1'b1, c_fill);
      check("fill_first_fetch", sample(), busy_at(5'd0));
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 1'b0, c_fill);
         step(1'b0, 1'b0, c_fill);
         step(1'b0, 1'b0, c_fill);
      end
      check("fetch_pc12", sample(), busy_at(5'd12));
      step(1'b0, 1'b0, c_halt);
      step(1'b0, 1'b0, c_halt);
      check("halt_entry", sample(),
            ex(5'd12, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      step(1'b0, 1'b0, c_halt);
      check("halt_hold", sample(),
            ex(5'd12, 1'b0, 3'd0, 3'd0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      step(1'b0, 1'b1, c_fill);
      check("halt_restart", sample(), busy_at(5'd0));

      // pc wraps 31 -> 0 after 32 LOADs
      for (int k = 0; k < 32; k++) begin
         step(1'b0, 1'b0, c_fill);
         step(1'b0, 1'b0, c_fill);
         step(1'b0, 1'b0, c_fill);
         if (k == 30) check("fetch_pc31", sample(), busy_at(5'd31));
      end
      check("pc_wrap", sample(), busy_at(5'd0));

      // reset in ADD EX2 aborts the instruction before its write
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, c_add);
      step(1'b0, 1'b0, c_add);
      step(1'b0, 1'b0, c_add);
      step(1'b0, 1'b1, c_add);
      check("ex2_before_rst", sample(),
            ex(5'd0, 1'b0, 3'd0, 3'd0, 2'b10, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      step(1'b1, 1'b1, c_add);
      check("rst_in_ex2", sample(), zero);
      step(1'b0, 1'b0, c_add);
      check("no_ex3_write", sample(), zero);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/proc_control_fsm.md
PROC_CONTROL_FSM -- requirements
Module: proc_control_fsm

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 run  input  1  start/restart request, sampled each clk.
REQ-005 code  input  23  instruction word from instruction ROM: [22:19] opcode, [18:16] rx, [15:13] ry, [15:0] imm.
REQ-006 pc  output  5  instruction ROM address.
REQ-007 rf_we  output  1  register-file write enable.
REQ-008 rf_waddr  output  3  register-file write address.
REQ-009 rf_raddr  output  3  register-file read address driven onto the bus.
REQ-010 bus_sel  output  2  bus source: 00 none, 01 imm, 10 register, 11 ALU result.
REQ-011 imm  output  16  immediate value for the bus.
REQ-012 a_load  output  1  latch bus into ALU operand register A.
REQ-013 alu_add  output  1  latch A + bus into ALU result register G.
REQ-014 busy  output  1  high in every state except IDLE and HALT.
REQ-015 done  output  1  one-cycle pulse on entry to HALT.
REQ-016 halted  output  1  high while in HALT.
REQ-017 illegal  output  1  high while halted on an undefined opcode (ILLEGAL_OP_TRAP_EN only; otherwise tied 0).

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EX1, EX2, EX3, HALT; control outputs are decoded from state and IR only, never directly from code.
REQ-019 IDLE: run=1 -> pc<=0, FETCH; else hold.
REQ-020 FETCH: pc drives ROM; IR<=code at clk edge; -> DECODE.
REQ-021 DECODE: opcode 0000 -> HALT; 0001/0010/0011 -> EX1; any other opcode -> pc<=pc+1, FETCH (NOP).
REQ-022 LOAD (0001) EX1: rf_we=1, rf_waddr=rx, bus_sel=01, imm=IR[15:0]; pc<=pc+1; -> FETCH; 3 cycles total.
REQ-023 MOV (0010) EX1: rf_raddr=ry, bus_sel=10, rf_we=1, rf_waddr=rx; pc<=pc+1; -> FETCH; 3 cycles total.
REQ-024 ADD (0011): EX1 rf_raddr=rx, bus_sel=10, a_load=1; EX2 rf_raddr=ry, bus_sel=10, alu_add=1; EX3 bus_sel=11, rf_we=1, rf_waddr=rx, pc<=pc+1, -> FETCH; 5 cycles total.
REQ-025 Exactly one rf_we cycle per LOAD/MOV/ADD; rf_we=0 in all other states.
REQ-026 pc SHALL increment modulo 32 (31 -> 0) with no flag.
REQ-027 HALT: pc holds at the halting address; done=1 for the entry cycle only; halted=1; run=1 -> pc<=0, halted/illegal clear, FETCH.
REQ-028 run while busy=1 SHALL be ignored.
REQ-029 Unused outputs in any state SHALL be 0 (imm=0 unless bus_sel=01).

Reset
REQ-030 rst=1 at any clk edge, including mid-instruction, SHALL force IDLE, pc=0, IR=0, and all outputs 0 on the next cycle; no partial write completes.
REQ-031 rst SHALL have priority over run.

Configuration
REQ-032 Macro ILLEGAL_OP_TRAP_EN defined: undefined opcode in DECODE -> HALT with illegal=1, done pulse, pc held; undefined: undefined opcode is a NOP (REQ-021), illegal tied 0.

Verification
REQ-033 rst, then run pulse, code=LOAD R0 0x000C -> FETCH at pc=0; third cycle rf_we=1, rf_waddr=0, bus_sel=01, imm=0x000C; pc=1 after.
REQ-034 code=MOV R5 R7 -> EX1 rf_raddr=7, rf_waddr=5, bus_sel=10, rf_we=1 for exactly one cycle.
REQ-035 code=ADD R3 R0 -> a_load with rf_raddr=3; next cycle alu_add with rf_raddr=0; next rf_we=1, rf_waddr=3, bus_sel=11; 5 cycles start to next FETCH.
REQ-036 code=0 at pc=12 -> done high one cycle, halted=1, pc stays 12; run -> FETCH at pc=0.
REQ-037 code opcode 0101 at pc=4: macro off -> no write, pc=5; macro on -> HALT, illegal=1, pc=4.
REQ-038 rst during ADD EX2 -> next cycle IDLE, pc=0, rf_we=0 and no EX3 write; run during busy has no effect.
